// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register file read port over indices 0..NUM_REGS-1,
// streams each word out on a valid/ready handshake and keeps a running sum.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] ck_q, ck_d;

  // Next-state logic; abort outranks every per-state transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    ck_d    = ck_q;
    if (abort && (state_q != StIdle)) begin
      // Checksum deliberately keeps its partial value.
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cnt_d   = '0;
            ck_d    = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          data_d  = RD1;
          idx_d   = cnt_q;
          last_d  = (cnt_q == LastIdx);
          valid_d = 1'b1;
          ck_d    = ck_q + RD1;
          state_d = StSend;
        end
        StSend: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              state_d = StDone;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = StFetch;
            end
          end
        end
        StDone: begin
          // Return the read address to 0 for IDLE.
          cnt_d   = '0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ck_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ck_q    <= ck_d;
    end
  end

  // Outputs; done is masked by abort so an aborted DONE cycle shows no pulse.
  always_comb begin
    A1        = cnt_q;
    out_data  = data_q;
    out_idx   = idx_q;
    out_valid = valid_q;
    out_last  = last_q;
    checksum  = ck_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone) && !abort;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table of dump scenarios checked against a
// register-array model, plus hand sequences for reset, idle abort and NUM_REGS=2.
module tb_reg_dump_reader;

  localparam int N = 32;

  logic        CLK = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [4:0]  a1, out_idx;
  logic [31:0] rd1, out_data, checksum;
  logic        out_valid, out_last, busy, done;
  logic [31:0] regs [32];

  logic        start2, abort2, ready2;
  logic [4:0]  a1_2, out_idx2;
  logic [31:0] rd1_2, out_data2, checksum2;
  logic        out_valid2, out_last2, busy2, done2;
  logic [31:0] regs2 [32];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign rd1   = regs[a1];
  assign rd1_2 = regs2[a1_2];

  reg_dump_reader #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5)) u_dut (
    .CLK(CLK), .rst(rst), .start(start), .abort(abort), .A1(a1), .RD1(rd1),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  reg_dump_reader #(.NUM_REGS(2), .DATA_W(32), .ADDR_W(5)) u_dut2 (
    .CLK(CLK), .rst(rst), .start(start2), .abort(abort2), .A1(a1_2), .RD1(rd1_2),
    .out_data(out_data2), .out_idx(out_idx2), .out_valid(out_valid2), .out_ready(ready2),
    .out_last(out_last2), .busy(busy2), .done(done2), .checksum(checksum2)
  );

  typedef struct {
    int          fill;       // 0: reg i = i+1, 1: all ones, 2: random
    int          abort_idx;  // -1: no abort
    int          stall_idx;
    int          stall_len;
    int          ready_pct;
    bit          noise;      // random start pulses while busy
    logic [31:0] exp_ck;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fill_regs(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       regs[i] = 32'(i + 1);
        1:       regs[i] = 32'hFFFF_FFFF;
        default: regs[i] = $urandom;
      endcase
    end
  endtask

  // Reference checksum: plain sum of the first n register words.
  function automatic logic [31:0] model_ck(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += regs[i];
    return s;
  endfunction

  task automatic run_dump(input vec_t v);
    int exp_idx  = 0;
    int k        = 0;
    int stall_c  = 0;
    bit hs_prev  = 0;
    bit held     = 0;
    bit first    = 1;
    bit fin      = 0;
    @(negedge CLK);
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    while (!fin && k < 2000) begin
      @(negedge CLK);
      k++;
      start = v.noise ? 1'($urandom_range(1)) : 1'b0;
      if (first && out_valid) begin
        chk("first_latency", k, 2);
        first = 0;
      end
      if (held) chk("held_valid", out_valid, 1);
      if (done) begin
        chk("done_after_last_hs", hs_prev, 1);
        chk("done_all_words", exp_idx, N);
        start = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("checksum_final", checksum, v.exp_ck);
        chk("a1_idle", a1, 0);
        fin = 1;
      end else if (out_valid) begin
        chk("word_idx", out_idx, exp_idx);
        chk("word_data", out_data, regs[exp_idx]);
        chk("word_last", out_last, exp_idx == N - 1);
        chk("busy_send", busy, 1);
        if (exp_idx == v.abort_idx) begin
          abort = 1'b1;
          out_ready = 1'($urandom_range(1));
          start = 1'($urandom_range(1));
          @(negedge CLK);
          chk("abort_busy", busy, 0);
          chk("abort_valid", out_valid, 0);
          chk("abort_last", out_last, 0);
          chk("abort_done", done, 0);
          chk("abort_a1", a1, 0);
          chk("abort_checksum", checksum, v.exp_ck);
          abort = 1'b0; start = 1'b0; out_ready = 1'b0;
          @(negedge CLK);
          chk("abort_no_done", done, 0);
          chk("abort_stays_idle", busy, 0);
          fin = 1;
        end else begin
          if (exp_idx == v.stall_idx && stall_c < v.stall_len) begin
            out_ready = 1'b0;
            stall_c++;
          end else begin
            out_ready = ($urandom_range(99) < v.ready_pct);
          end
          held    = !out_ready;
          hs_prev = out_ready;
          if (out_ready) exp_idx++;
        end
      end else begin
        chk("busy_fetch", busy, 1);
        out_ready = 1'($urandom_range(1));
        held    = 0;
        hs_prev = 0;
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int          nw;
    int          dcnt;
    logic [31:0] w_data [2];
    logic [4:0]  w_idx  [2];
    logic        w_last [2];
    logic [31:0] held_ck;

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 32; i++) regs2[i] = '0;
    fill_regs(0);

    vecs[0] = '{fill: 0, abort_idx: -1, stall_idx: -1, stall_len: 0, ready_pct: 100,
                noise: 0, exp_ck: 32'd528};
    vecs[1] = '{fill: 0, abort_idx: -1, stall_idx: 3, stall_len: 5, ready_pct: 100,
                noise: 0, exp_ck: 32'd528};
    vecs[2] = '{fill: 0, abort_idx: 10, stall_idx: -1, stall_len: 0, ready_pct: 100,
                noise: 0, exp_ck: 32'd66};
    vecs[3] = '{fill: 1, abort_idx: -1, stall_idx: -1, stall_len: 0, ready_pct: 100,
                noise: 1, exp_ck: 32'hFFFF_FFE0};
    vecs[4] = '{fill: 2, abort_idx: -1, stall_idx: 7, stall_len: 3, ready_pct: 60,
                noise: 1, exp_ck: 32'd0};
    vecs[5] = '{fill: 2, abort_idx: 20, stall_idx: -1, stall_len: 0, ready_pct: 50,
                noise: 0, exp_ck: 32'd0};

    #12;
    chk("rst_a1", a1, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    @(negedge CLK);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_wait_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      fill_regs(v.fill);
      if (v.fill == 2) v.exp_ck = model_ck((v.abort_idx >= 0) ? v.abort_idx + 1 : N);
      run_dump(v);
      repeat (3) @(negedge CLK);
      chk("checksum_hold_idle", checksum, v.exp_ck);
    end

    // Abort while idle must not disturb anything.
    held_ck = checksum;
    @(negedge CLK); abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_checksum", checksum, held_ck);

    // Reset between clock edges in the middle of a dump.
    fill_regs(0);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge CLK);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_idx", out_idx, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_a1", a1, 0);
    chk("midrst_checksum", checksum, 0);
    out_ready = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    run_dump(vecs[0]);

    // NUM_REGS=2 instance.
    regs2[0] = 32'h0000_00A5;
    regs2[1] = 32'h0000_005A;
    nw = 0; dcnt = 0;
    @(negedge CLK); start2 = 1'b1; ready2 = 1'b1;
    @(negedge CLK); start2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid2) begin
        if (nw < 2) begin
          w_data[nw] = out_data2; w_idx[nw] = out_idx2; w_last[nw] = out_last2;
        end
        nw++;
      end
      if (done2) dcnt++;
      @(negedge CLK);
    end
    chk("n2_words", nw, 2);
    if (nw >= 2) begin
      chk("n2_idx0", w_idx[0], 0);
      chk("n2_idx1", w_idx[1], 1);
      chk("n2_data0", w_data[0], 32'hA5);
      chk("n2_data1", w_data[1], 32'h5A);
      chk("n2_last0", w_last[0], 0);
      chk("n2_last1", w_last[1], 1);
    end
    chk("n2_done_pulses", dcnt, 1);
    chk("n2_checksum", checksum2, 32'hFF);
    chk("n2_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
